axi_lite_slave: RTL and testbench
=================================

Name: axi_lite_slave

Overview:
AXI4-Lite slave exposing a bank of 32-bit read/write registers to an AXI4-Lite master (CPU/interconnect side).
- Write channel (AW/W/B) and read channel (AR/R) are independent FSMs.
- Registers are byte-writable through WSTRB.
- Zero-wait-state acceptance: single-cycle-pulsed VALIDs complete when the slave is idle.

Parameters:
ADDR_WIDTH, 32, AWADDR/ARADDR width.
DATA_WIDTH, 32, data width; only 32 is supported.
NUM_REGS, 16, number of registers; must be a power of 2, range 2..256.

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes, bit i enables WDATA[8i+7:8i]
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response, 00 OKAY / 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (async assert, sync release):
  - All registers 0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; FSMs to IDLE.
  - AWREADY/WREADY/ARREADY forced 0 while ARESET=1.
- Decode:
  - Register index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
  - In range iff addr < NUM_REGS*4.
- Write FSM states:
  - W_IDLE: AWREADY=1 until AW captured; WREADY=1 until W captured.
    - AW and W may arrive in the same cycle or in either order, any gap.
    - Each is latched on its own handshake edge; its READY drops until the response completes.
    - When both are held (including same edge), go to W_RESP.
  - Register write occurs on the edge that captures the second of AW/W.
    - Only bytes with WSTRB=1 are updated; WSTRB=0000 writes nothing but still responds.
  - W_RESP: BVALID=1 from the cycle after completion; BVALID and BRESP are held stable until BREADY=1.
    - On the BVALID&BREADY edge: BVALID=0, return to W_IDLE, READYs high next cycle.
  - Latency: AW+W same edge N → BVALID visible in cycle N+1; with BREADY tied 1, the next write is accepted at edge N+2.
- Read FSM states:
  - R_IDLE: ARREADY=1.
    - On ARVALID handshake, RDATA is loaded from the register at that edge, RVALID=1 next cycle, ARREADY=0.
  - R_DATA: RDATA, RRESP and RVALID are held stable until RREADY=1; then RVALID=0 and return to R_IDLE.
- Simultaneous events:
  - A read and a write to the same register at the same edge → read returns the pre-write value.
  - A write committed on an earlier edge is always visible to a later read.
- VALID deassertion after handshake has no effect; VALID without READY is simply waited on.
- Reset mid-transaction aborts everything immediately: no pending response survives; registers cleared.

Optional Feature:
- Macro AXIL_SLVERR_EN.
- Defined:
  - Out-of-range write: no register changes, BRESP=10.
  - Out-of-range read: RDATA=0, RRESP=10.
- Undefined:
  - Out-of-range accesses complete with OKAY (00); writes are ignored; reads return 0.
- Handshake timing is identical in both builds.

Test Plan:
- Reset release, AW=0x04, WDATA=0x12345678, WSTRB=1111, AWVALID/WVALID pulsed one cycle, BREADY=1 → BVALID one cycle later, BRESP=00. Then AR=0x04 pulsed one cycle, RREADY=1 → RVALID next cycle, RDATA=0x12345678, RRESP=00.
- Partial write: reg 0x08=0x12345678, then WDATA=0xAABBCCDD with WSTRB=0011 → read 0x08 returns 0x1234CCDD; WSTRB=0000 leaves the value unchanged but still returns BRESP=00.
- Split channels: AWVALID at cycle 0, WVALID at cycle 3 (and the reverse order) → AWREADY low after capture, write to 0x0C lands, single BVALID after the W handshake.
- Backpressure: BREADY=0 for 3 cycles, then RREADY=0 for 3 cycles → BVALID/BRESP and RVALID/RDATA held stable; AWREADY/ARREADY stay 0 until the response completes.
- Out-of-range address 0x40 (NUM_REGS=16) → with AXIL_SLVERR_EN: BRESP=10, RRESP=10, RDATA=0, no register modified; without it: BRESP=RRESP=00, RDATA=0.
- Assert ARESET while BVALID=1 after writing 0xDEADBEEF to 0x00 → BVALID=0 immediately; after release, read 0x00 returns 0x00000000.

Source files
------------

// File: rtl/axi_lite_slave.sv
// AXI4-Lite register-bank slave with independent write and read FSMs.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LIM_W  = ADDR_WIDTH + 1;
    localparam logic [LIM_W-1:0] LIMIT = LIM_W'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in, ar_in;
    logic [IDX_W-1:0]      wr_idx, ar_idx;

    assign AWREADY = !ARESET && (wstate_q == W_IDLE) && !aw_done_q;
    assign WREADY  = !ARESET && (wstate_q == W_IDLE) && !w_done_q;
    assign ARREADY = !ARESET && (rstate_q == R_IDLE);
    assign BVALID  = (wstate_q == W_RESP);
    assign RVALID  = (rstate_q == R_DATA);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The second of AW/W to arrive is taken straight from the bus
    assign wr_addr = aw_done_q ? awaddr_q : AWADDR;
    assign wr_data = w_done_q ? wdata_q : WDATA;
    assign wr_strb = w_done_q ? wstrb_q : WSTRB;
    assign wr_in   = {1'b0, wr_addr} < LIMIT;
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign ar_in   = {1'b0, ARADDR} < LIMIT;
    assign ar_idx  = ARADDR[IDX_W+1:2];

    always_comb begin
        wstate_d  = wstate_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    if (wr_in) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) begin
                                regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end
                    bresp_d   = wr_in ? RESP_OKAY : RESP_OOR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d  = ar_in ? regs_q[ar_idx] : '0;
                    rresp_d  = ar_in ? RESP_OKAY : RESP_OOR;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= '{default: '0};
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave.sv
// Self-checking bench for axi_lite_slave: directed AXI-Lite traffic
// against a register-array model with response queues.
module tb_axi_lite_slave;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [16];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    logic        b_hold = 1'b0;
    logic [1:0]  b_prev;
    logic        r_hold = 1'b0;
    logic [33:0] r_prev;

    axi_lite_slave dut (
        .ACLK(clk), .ARESET(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [33:0] act,
                       input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return (a < 32'd64) ? 2'b00 : ERR;
    endfunction

    function automatic logic [33:0] m_read(input logic [31:0] a);
        if (a < 32'd64) return {2'b00, model[a[5:2]]};
        return {ERR, 32'h0};
    endfunction

    task automatic m_write(input logic [31:0] a, d, input logic [3:0] s);
        if (a < 32'd64) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // Checks every response handshake against the model queues and
    // the stability of a stalled response
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_awready", AWREADY, 0);
            chk("rst_wready", WREADY, 0);
            chk("rst_arready", ARREADY, 0);
            chk("rst_bvalid", BVALID, 0);
            chk("rst_rvalid", RVALID, 0);
            b_hold = 1'b0;
            r_hold = 1'b0;
        end else begin
            if (BVALID) begin
                chk("awready_busy", AWREADY, 0);
                chk("wready_busy", WREADY, 0);
                if (b_hold) chk("bresp_stable", BRESP, b_prev);
                if (BREADY) begin
                    if (bq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL b_unexpected: BVALID=1 expected 0 at %0t", $time);
                    end else begin
                        chk("bresp", BRESP, bq.pop_front());
                    end
                    b_hold = 1'b0;
                end else begin
                    b_hold = 1'b1;
                    b_prev = BRESP;
                end
            end else begin
                b_hold = 1'b0;
            end
            if (RVALID) begin
                chk("arready_busy", ARREADY, 0);
                if (r_hold) chk("r_stable", {RRESP, RDATA}, r_prev);
                if (RREADY) begin
                    if (rq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL r_unexpected: RVALID=1 expected 0 at %0t", $time);
                    end else begin
                        chk("rresp_rdata", {RRESP, RDATA}, rq.pop_front());
                    end
                    r_hold = 1'b0;
                end else begin
                    r_hold = 1'b1;
                    r_prev = {RRESP, RDATA};
                end
            end else begin
                r_hold = 1'b0;
            end
        end
    end

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                            input int daw, input int dw);
        int last;
        last = (daw > dw) ? daw : dw;
        @(posedge clk); #1;
        for (int c = 0; c <= last; c++) begin
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = (c == daw);
            WVALID  = (c == dw);
            @(negedge clk);
            if (c == daw) chk("awready_idle", AWREADY, 1);
            else if (c > daw) chk("awready_low_after_aw", AWREADY, 0);
            if (c == dw) chk("wready_idle", WREADY, 1);
            else if (c > dw) chk("wready_low_after_w", WREADY, 0);
            chk("bvalid_early", BVALID, 0);
            @(posedge clk); #1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        bq.push_back(m_resp(a));
        m_write(a, d, s);
        @(negedge clk);
        chk("bvalid_latency", BVALID, 1);
    endtask

    task automatic wait_b_done();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!BVALID) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_timeout: BVALID=1 expected 0 at %0t", $time);
        end
        chk("awready_after_b", AWREADY, 1);
        chk("wready_after_b", WREADY, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] lit);
        @(posedge clk); #1;
        ARADDR  = a;
        ARVALID = 1'b1;
        @(negedge clk);
        chk("arready_idle", ARREADY, 1);
        @(posedge clk); #1;
        rq.push_back(m_read(a));
        ARVALID = 1'b0;
        @(negedge clk);
        chk("rvalid_latency", RVALID, 1);
        chk("rdata_literal", RDATA, lit);
    endtask

    task automatic wait_r_done();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!RVALID) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL r_timeout: RVALID=1 expected 0 at %0t", $time);
        end
        chk("arready_after_r", ARREADY, 1);
    endtask

    initial begin
        AWADDR = 0; WDATA = 0; WSTRB = 0; AWVALID = 0; WVALID = 0;
        ARADDR = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_awready", AWREADY, 1);
        chk("init_wready", WREADY, 1);
        chk("init_arready", ARREADY, 1);
        chk("init_bvalid", BVALID, 0);
        chk("init_rvalid", RVALID, 0);
        chk("init_rdata", RDATA, 0);
        chk("init_bresp", BRESP, 0);
        chk("init_rresp", RRESP, 0);

        do_write(32'h04, 32'h12345678, 4'hF, 0, 0); wait_b_done();
        do_read(32'h04, 32'h12345678); wait_r_done();

        do_write(32'h08, 32'h12345678, 4'hF, 0, 0); wait_b_done();
        do_write(32'h08, 32'hAABBCCDD, 4'h3, 0, 0); wait_b_done();
        do_read(32'h08, 32'h1234CCDD); wait_r_done();
        do_write(32'h08, 32'hFFFFFFFF, 4'h0, 0, 0); wait_b_done();
        do_read(32'h08, 32'h1234CCDD); wait_r_done();
        do_write(32'h0B, 32'h00EE0000, 4'h4, 0, 0); wait_b_done();
        do_read(32'h08, 32'h12EECCDD); wait_r_done();

        do_write(32'h0C, 32'h0BADF00D, 4'hF, 0, 3); wait_b_done();
        do_read(32'h0C, 32'h0BADF00D); wait_r_done();
        do_write(32'h0C, 32'h600DCAFE, 4'hF, 3, 0); wait_b_done();
        do_read(32'h0C, 32'h600DCAFE); wait_r_done();

        BREADY = 1'b0;
        do_write(32'h10, 32'h11111111, 4'hF, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bvalid_held", BVALID, 1);
        end
        @(posedge clk); #1 BREADY = 1'b1;
        wait_b_done();
        RREADY = 1'b0;
        do_read(32'h10, 32'h11111111);
        repeat (3) begin
            @(negedge clk);
            chk("rvalid_held", RVALID, 1);
            chk("rdata_held", RDATA, 32'h11111111);
        end
        @(posedge clk); #1 RREADY = 1'b1;
        wait_r_done();

        // Read and write of the same register on one edge
        @(posedge clk); #1;
        AWADDR = 32'h10; WDATA = 32'h22222222; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h10; ARVALID = 1'b1;
        rq.push_back(m_read(32'h10));
        @(negedge clk);
        chk("same_edge_awready", AWREADY, 1);
        chk("same_edge_arready", ARREADY, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        bq.push_back(m_resp(32'h10));
        m_write(32'h10, 32'h22222222, 4'hF);
        @(negedge clk);
        chk("same_edge_bvalid", BVALID, 1);
        chk("same_edge_rvalid", RVALID, 1);
        chk("same_edge_old_data", RDATA, 32'h11111111);
        wait_b_done();
        wait_r_done();
        do_read(32'h10, 32'h22222222); wait_r_done();

        do_write(32'h00, 32'h5A5A5A5A, 4'hF, 0, 0); wait_b_done();
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
        chk("oor_bresp", BRESP, ERR);
        wait_b_done();
        do_read(32'h40, 32'h0);
        chk("oor_rresp", RRESP, ERR);
        wait_r_done();
        do_read(32'h00, 32'h5A5A5A5A); wait_r_done();

        BREADY = 1'b0;
        do_write(32'h00, 32'hDEADBEEF, 4'hF, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_mid_bvalid", BVALID, 0);
        chk("rst_mid_awready", AWREADY, 0);
        model_clear();
        bq.delete();
        rq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        BREADY = 1'b1;
        do_read(32'h00, 32'h0); wait_r_done();
        do_read(32'h04, 32'h0); wait_r_done();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
